// File: rtl/param_datapath.sv
// -----------------------------------------------------------------------------
// param_datapath
//   Parametrised register-file datapath: NREGS x WIDTH registers, two
//   combinational read ports, an 8-op ALU, a write-back mux (external data vs
//   ALU result), an ALU bit-0 capture register and a {Z,N,C} status register.
//   With DP_MUL_EN defined, a shift-and-add multiply sequencer shares the
//   register file (IDLE -> RUN -> WB -> IDLE). While the sequencer runs, it
//   owns the file and the w/loadb/loads/start inputs are ignored.
//
// Parameters
//   WIDTH    data width (>= 4)
//   NREGS    register count (>= 2); address width RW = $clog2(NREGS)
//   OUT_REG  register index driven onto out_o
//
// Configuration macro
//   DP_MUL_EN  defined: multiply sequencer present.
//              undefined: start_i ignored, busy_o = done_o = 0.
//
// Ports
//   clk       clock, all state on posedge
//   rst_n     asynchronous active-low reset
//   w_i       write enable for R[rd_i]
//   sel_i     write source: 1 = in_i, 0 = ALU result
//   rd_i      write address (also multiply destination)
//   ri_i      read port A address
//   rj_i      read port B address
//   in_i      external write data
//   aop_i     ALU op: 0 LSR, 1 LSL, 2 ADD, 3 MOV, 4 SUB, 5 AND, 6 XOR, 7 ASR
//   loadb_i   capture ALU bit 0 into lsb_o
//   loads_i   capture {Z,N,C} of the ALU result into status_o
//   start_i   start multiply R[rd_i] <= R[ri_i] * R[rj_i] (low WIDTH bits)
//   busy_o    sequencer owns the register file
//   done_o    one-cycle pulse in the multiply write-back cycle
//   status_o  {Z,N,C}
//   lsb_o     captured ALU bit 0
//   out_o     R[OUT_REG]
// -----------------------------------------------------------------------------
module param_datapath #(
  parameter  int WIDTH   = 16,
  parameter  int NREGS   = 4,
  parameter  int OUT_REG = NREGS - 1,
  localparam int RW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_i,
  input  logic             sel_i,
  input  logic [RW-1:0]    rd_i,
  input  logic [RW-1:0]    ri_i,
  input  logic [RW-1:0]    rj_i,
  input  logic [WIDTH-1:0] in_i,
  input  logic [2:0]       aop_i,
  input  logic             loadb_i,
  input  logic             loads_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [2:0]       status_o,
  output logic             lsb_o,
  output logic [WIDTH-1:0] out_o
);

  // Addresses beyond NREGS exist only when NREGS is not a power of two.
  function automatic logic in_range(input logic [RW-1:0] addr);
    return int'(addr) < NREGS;
  endfunction

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [2:0]       status_q;
  logic             lsb_q;

  logic [WIDTH-1:0] a_val, b_val;
  logic [WIDTH-1:0] aout;
  logic             c_flag;
  logic [WIDTH:0]   ext;
  logic [2:0]       flags;

  logic             accept;
  logic             wb_en;
  logic [RW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;

  // ---------------------------------------------------------------------------
  // Read ports: out-of-range addresses read as zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    a_val = '0;
    b_val = '0;
    if (in_range(ri_i)) a_val = regs_q[ri_i];
    if (in_range(rj_i)) b_val = regs_q[rj_i];
  end

  // ---------------------------------------------------------------------------
  // ALU. ext is one bit wider so ADD carry / SUB borrow fall out of the MSB.
  // ---------------------------------------------------------------------------
  always_comb begin
    aout   = '0;
    c_flag = 1'b0;
    ext    = '0;
    case (aop_i)
      3'b000: begin aout = {1'b0, a_val[WIDTH-1:1]};          c_flag = a_val[0];       end
      3'b001: begin aout = {a_val[WIDTH-2:0], 1'b0};          c_flag = a_val[WIDTH-1]; end
      3'b010: begin
        ext    = {1'b0, a_val} + {1'b0, b_val};
        aout   = ext[WIDTH-1:0];
        c_flag = ext[WIDTH];
      end
      3'b011: aout = a_val;
      3'b100: begin
        // MSB of the widened difference is the borrow; C means "no borrow".
        ext    = {1'b0, a_val} - {1'b0, b_val};
        aout   = ext[WIDTH-1:0];
        c_flag = ~ext[WIDTH];
      end
      3'b101: aout = a_val & b_val;
      3'b110: aout = a_val ^ b_val;
      default: begin aout = {a_val[WIDTH-1], a_val[WIDTH-1:1]}; c_flag = a_val[0]; end
    endcase
  end

  assign flags  = {(aout == '0), aout[WIDTH-1], c_flag};
  assign accept = ~busy_o;

`ifdef DP_MUL_EN
  // ---------------------------------------------------------------------------
  // Shift-and-add multiply sequencer. Operands are captured at start, so later
  // register writes never disturb a multiply in flight.
  // ---------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam int         CW     = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    dst_q, dst_d;

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dst_d   = dst_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_a_d  = a_val;
          op_b_d  = b_val;
          dst_d   = rd_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (op_b_q[0]) acc_d = acc_q + op_a_q;
        op_a_d = op_a_q << 1;
        op_b_d = op_b_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        // cnt_q counts completed steps; the WIDTH-th step moves to write-back.
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      dst_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dst_q   <= dst_d;
    end
  end

  assign busy_o  = (state_q != S_IDLE);
  assign done_o  = (state_q == S_WB);
  assign wb_en   = done_o;
  assign wb_addr = dst_q;
  assign wb_data = acc_q;
`else
  logic unused_start;
  assign unused_start = start_i;
  assign busy_o       = 1'b0;
  assign done_o       = 1'b0;
  assign wb_en        = 1'b0;
  assign wb_addr      = '0;
  assign wb_data      = '0;
`endif

  // ---------------------------------------------------------------------------
  // Register file. The host write and the multiply write-back never coincide:
  // write-back happens only while busy, when host writes are blocked.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this register file is a handful of flops that must read zero out
      // of reset, so it is reset explicitly; a RAM macro would not be.
      for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
    end else begin
      if (accept && w_i && in_range(rd_i)) regs_q[rd_i] <= sel_i ? in_i : aout;
      if (wb_en && in_range(wb_addr))      regs_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
      lsb_q    <= 1'b0;
    end else begin
      if (accept && loads_i) status_q <= flags;
      if (accept && loadb_i) lsb_q    <= aout[0];
    end
  end

  assign status_o = status_q;
  assign lsb_o    = lsb_q;
  assign out_o    = regs_q[OUT_REG];

endmodule

// File: tb/tb_param_datapath.sv
// -----------------------------------------------------------------------------
// tb_param_datapath
//   Self-checking bench for param_datapath. Main instance WIDTH=16, NREGS=4;
//   a second instance WIDTH=8, NREGS=3 exercises out-of-range addresses.
//   A behavioural model (arithmetic on integers, multiply as a plain product
//   released after a fixed cycle count) predicts every observable output.
//   Works with or without DP_MUL_EN defined.
// -----------------------------------------------------------------------------
module tb_param_datapath;
  localparam int WIDTH   = 16;
  localparam int NREGS   = 4;
  localparam int OUT_REG = NREGS - 1;
  localparam int RW      = 2;
  localparam int W2      = 8;
  localparam int N2      = 3;

  localparam int unsigned MASK = (1 << WIDTH) - 1;
  localparam int unsigned HALF = 1 << (WIDTH - 1);
  localparam int          MUL_DONE_PHASE = WIDTH + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic             w, sel, loadb, loads, start;
  logic [RW-1:0]    rd, ri, rj;
  logic [WIDTH-1:0] din;
  logic [2:0]       aop;
  logic             busy, done, lsb;
  logic [2:0]       status;
  logic [WIDTH-1:0] dout;

  // Small instance
  logic             u2_w, u2_sel, u2_loadb, u2_loads, u2_start;
  logic [1:0]       u2_rd, u2_ri, u2_rj;
  logic [W2-1:0]    u2_din;
  logic [2:0]       u2_aop;
  logic             u2_busy, u2_done, u2_lsb;
  logic [2:0]       u2_status;
  logic [W2-1:0]    u2_dout;

  param_datapath #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk(clk), .rst_n(rst_n), .w_i(w), .sel_i(sel), .rd_i(rd), .ri_i(ri), .rj_i(rj),
    .in_i(din), .aop_i(aop), .loadb_i(loadb), .loads_i(loads), .start_i(start),
    .busy_o(busy), .done_o(done), .status_o(status), .lsb_o(lsb), .out_o(dout)
  );

  param_datapath #(.WIDTH(W2), .NREGS(N2)) dut2 (
    .clk(clk), .rst_n(rst_n), .w_i(u2_w), .sel_i(u2_sel), .rd_i(u2_rd), .ri_i(u2_ri),
    .rj_i(u2_rj), .in_i(u2_din), .aop_i(u2_aop), .loadb_i(u2_loadb), .loads_i(u2_loads),
    .start_i(u2_start), .busy_o(u2_busy), .done_o(u2_done), .status_o(u2_status),
    .lsb_o(u2_lsb), .out_o(u2_dout)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int unsigned m_r [NREGS];
  int unsigned m_status;
  int unsigned m_lsb;
  int          m_phase;     // 0 = idle, 1..WIDTH+1 = cycles since start accepted
  int unsigned m_prod;
  int          m_dst;

  function automatic int unsigned ref_alu(input int op, input int unsigned a,
                                          input int unsigned b, output int unsigned flg);
    int unsigned r;
    int unsigned c;
    c = 0;
    case (op)
      0: begin r = a / 2;               c = a % 2;              end
      1: begin r = (a * 2) & MASK;      c = (a >= HALF) ? 1 : 0; end
      2: begin r = (a + b) & MASK;      c = (a + b > MASK) ? 1 : 0; end
      3: r = a;
      4: begin r = (a - b) & MASK;      c = (a >= b) ? 1 : 0;    end
      5: r = a & b;
      6: r = a ^ b;
      default: begin r = a / 2 + ((a >= HALF) ? HALF : 0); c = a % 2; end
    endcase
    flg = ((r == 0) ? 4 : 0) + ((r >= HALF) ? 2 : 0) + c;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NREGS; k++) m_r[k] = 0;
    m_status = 0;
    m_lsb    = 0;
    m_phase  = 0;
    m_prod   = 0;
    m_dst    = 0;
  endtask

  // Compare outputs for the current cycle, advance the model across one edge,
  // then wait for that edge (caller is positioned 1 time unit after an edge).
  task automatic step(input string tag);
    int unsigned a, b, res, flg;
    bit          acc;
    check({tag, " out"},    dout,   m_r[OUT_REG]);
    check({tag, " status"}, status, m_status);
    check({tag, " lsb"},    lsb,    m_lsb);
    check({tag, " busy"},   busy,   (m_phase != 0));
    check({tag, " done"},   done,   (m_phase == MUL_DONE_PHASE));
    a   = m_r[ri];
    b   = m_r[rj];
    res = ref_alu(int'(aop), a, b, flg);
    acc = (m_phase == 0);
`ifdef DP_MUL_EN
    if (m_phase == MUL_DONE_PHASE) begin
      if (m_dst < NREGS) m_r[m_dst] = m_prod;
      m_phase = 0;
    end else if (m_phase != 0) begin
      m_phase++;
    end else if (start) begin
      m_prod  = (a * b) & MASK;
      m_dst   = int'(rd);
      m_phase = 1;
    end
`endif
    if (acc && w)     m_r[rd]  = sel ? int'(din) : res;
    if (acc && loadb) m_lsb    = res & 1;
    if (acc && loads) m_status = flg;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w = 0; sel = 0; loadb = 0; loads = 0; start = 0;
    rd = '0; ri = '0; rj = '0; din = '0; aop = '0;
  endtask

  task automatic idle2();
    u2_w = 0; u2_sel = 0; u2_loadb = 0; u2_loads = 0; u2_start = 0;
    u2_rd = '0; u2_ri = '0; u2_rj = '0; u2_din = '0; u2_aop = '0;
  endtask

  task automatic tick2();
    @(posedge clk);
    #1;
  endtask

  // Assert reset between clock edges and check outputs clear immediately.
  task automatic reset_mid_cycle(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, " out"},    dout,    0);
    check({tag, " status"}, status,  0);
    check({tag, " lsb"},    lsb,     0);
    check({tag, " busy"},   busy,    0);
    check({tag, " done"},   done,    0);
    check({tag, " u2 out"}, u2_dout, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  int done_cnt;
  int done_at;
  int unsigned pick;

  initial begin
    idle();
    idle2();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ---- reset state ----
    check("reset out",    dout,   0);
    check("reset status", status, 0);
    check("reset busy",   busy,   0);
    check("reset done",   done,   0);
    step("reset");

    // ---- ADD / LSL flags ----
    w = 1; sel = 1; rd = 0; din = 16'h8001; step("wr r0");
    rd = 1; din = 16'h0003;                 step("wr r1");
    sel = 0; rd = 3; aop = 3'b010; ri = 0; rj = 1; loads = 1; step("add");
    check("add out",    dout,   16'h8004);
    check("add status", status, 3'b010);
    w = 0; aop = 3'b001; ri = 0; loads = 1; loadb = 1; step("lsl");
    check("lsl status", status, 3'b001);
    check("lsl lsb",    lsb,    0);

    // ---- SUB borrow / zero ----
    loadb = 0; aop = 3'b100; ri = 1; rj = 0; step("sub borrow");
    check("sub borrow status", status, 3'b010);
    rj = 1; step("sub zero");
    check("sub zero status", status, 3'b101);

    // ---- multiply ----
    idle();
    w = 1; sel = 1; rd = 0; din = 16'h0123; step("wr r0 mul");
    rd = 1; din = 16'h0045;                 step("wr r1 mul");
    idle();
    start = 1; rd = 3; ri = 0; rj = 1;      step("mul start");
    idle();
`ifdef DP_MUL_EN
    done_cnt = 0;
    done_at  = 0;
    for (int k = 1; k <= WIDTH + 1; k++) begin
      if (done) begin
        done_cnt++;
        done_at = k;
      end
      idle();
      if (k == 3) begin
        // everything here must be ignored while busy
        w = 1; sel = 1; rd = 3; din = 16'hDEAD; start = 1;
        loads = 1; loadb = 1; aop = 3'b011; ri = 1;
      end
      step("mul run");
    end
    check("mul done pulses", done_cnt, 1);
    check("mul done cycle",  done_at,  WIDTH + 1);
    check("mul out",         dout,     16'h4E6F);
    check("mul status kept", status,   3'b101);
    check("mul lsb kept",    lsb,      0);
    check("mul busy clear",  busy,     0);
    // back-to-back start right after write-back
    start = 1; rd = 2; ri = 3; rj = 1; step("b2b start");
    idle();
    check("b2b busy", busy, 1);
    step("b2b run");
    step("b2b run");
`else
    for (int k = 0; k < 4; k++) begin
      start = 1; rd = 3; ri = 0; rj = 1;
      step("nomul start");
      check("nomul busy", busy, 0);
      check("nomul done", done, 0);
    end
    check("nomul out", dout, 16'h8004);
    idle();
`endif

    // ---- asynchronous reset mid-run ----
    reset_mid_cycle("rst mid");
    for (int k = 0; k < WIDTH + 4; k++) step("post rst");

    // ---- out-of-range addresses (NREGS=3, WIDTH=8) ----
    u2_w = 1; u2_sel = 1; u2_rd = 3; u2_din = 8'hAA; tick2();
    u2_rd = 2; u2_din = 8'h5A;                        tick2();
    check("u2 oob write out", u2_dout, 8'h5A);
    u2_w = 0; u2_aop = 3'b011; u2_ri = 3; u2_loads = 1; tick2();
    check("u2 oob read zero", u2_status, 3'b100);
    u2_ri = 2; tick2();
    check("u2 mov status", u2_status, 3'b000);
    u2_aop = 3'b001; u2_loadb = 1; tick2();
    check("u2 lsl status", u2_status, 3'b010);
    check("u2 lsl lsb",    u2_lsb,    0);
    idle2();
`ifdef DP_MUL_EN
    u2_start = 1; u2_rd = 3; u2_ri = 2; u2_rj = 2; tick2();
    idle2();
    done_cnt = 0;
    for (int k = 0; k < W2 + 4; k++) begin
      if (u2_done) done_cnt++;
      tick2();
    end
    check("u2 oob mul done", done_cnt, 1);
    check("u2 oob mul out",  u2_dout,  8'h5A);
    check("u2 oob mul busy", u2_busy,  0);
`else
    u2_start = 1; u2_rd = 2; u2_ri = 2; u2_rj = 2;
    for (int k = 0; k < 3; k++) begin
      tick2();
      check("u2 nomul busy", u2_busy, 0);
      check("u2 nomul done", u2_done, 0);
    end
    check("u2 nomul out", u2_dout, 8'h5A);
    idle2();
`endif

    // ---- randomized run against the model ----
    for (int i = 0; i < 3000; i++) begin
      w     = ($urandom_range(0, 1) == 1);
      sel   = ($urandom_range(0, 1) == 1);
      loadb = ($urandom_range(0, 1) == 1);
      loads = ($urandom_range(0, 1) == 1);
      start = ($urandom_range(0, 5) == 0);
      rd    = RW'($urandom_range(0, NREGS - 1));
      ri    = RW'($urandom_range(0, NREGS - 1));
      rj    = RW'($urandom_range(0, NREGS - 1));
      aop   = 3'($urandom_range(0, 7));
      pick  = $urandom_range(0, 7);
      case (pick)
        0:       din = 16'h0000;
        1:       din = 16'hFFFF;
        2:       din = 16'h8000;
        3:       din = 16'h0001;
        default: din = WIDTH'($urandom);
      endcase
      step("rand");
    end
    idle();
    step("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
